// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache (1 or 2 ways, LRU) with
// multi-word blocks filled one word at a time from the memory controller,
// a synchronous flush and saturating hit/miss counters.
module icache_assoc #(
  parameter int SETS        = 16,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_W   = $clog2(BLOCK_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = 30 - OFF_W - IDX_W;
  localparam int CNT_W   = (OFF_W == 0) ? 1 : OFF_W;
  localparam int LINES   = WAYS * SETS;
  localparam int LINE_AW = $clog2(LINES);
  localparam int WORDS   = LINES * BLOCK_WORDS;
  localparam int WORD_AW = $clog2(WORDS);

  typedef enum logic {LOOKUP, FILL} state_t;

  state_t             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [31:0]        data_q [WORDS];
  logic [SETS-1:0]    lru_q;
  logic [TAG_W-1:0]   fillTag_q;
  logic [IDX_W-1:0]   fillIdx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               victim_q;
  logic [31:0]        hitCount_q;
  logic [31:0]        missCount_q;

  logic [29:0]        wordAddr;
  logic [IDX_W-1:0]   reqIdx;
  logic [TAG_W-1:0]   reqTag;
  logic [CNT_W-1:0]   reqOff;
  logic               lookupHit;
  logic               hitWay;
  logic               victim;
  logic               lastWord;
  logic               fillAccept;
  logic [29:0]        fillWord;

  // Ways of one set sit SETS lines apart in the flat tag/valid storage.
  function automatic logic [LINE_AW-1:0] lineAddr(input logic way, input logic [IDX_W-1:0] idx);
    return LINE_AW'(32'(way) * 32'(SETS) + 32'(idx));
  endfunction

  // Words of one line are contiguous in the flat data storage.
  function automatic logic [WORD_AW-1:0] wordSlot(input logic [LINE_AW-1:0] line,
                                                  input logic [CNT_W-1:0] off);
    return WORD_AW'(32'(line) * 32'(BLOCK_WORDS) + (32'(off) & 32'(BLOCK_WORDS - 1)));
  endfunction

  assign wordAddr   = imemaddr[31:2];
  assign reqIdx     = IDX_W'(wordAddr >> OFF_W);
  assign reqTag     = TAG_W'(wordAddr >> (OFF_W + IDX_W));
  assign reqOff     = CNT_W'(wordAddr & 30'(BLOCK_WORDS - 1));
  assign lastWord   = (cnt_q == CNT_W'(BLOCK_WORDS - 1));
  assign fillAccept = (state_q == FILL) && !flush && !iwait;

  // Tag compare across all ways of the addressed set.
  always_comb begin
    lookupHit = 1'b0;
    hitWay    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lineAddr(1'(w), reqIdx)] && (tag_q[lineAddr(1'(w), reqIdx)] == reqTag)) begin
        lookupHit = 1'b1;
        hitWay    = 1'(w);
      end
    end
  end

  // Victim choice: an empty way first (lowest number), otherwise the LRU way.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!valid_q[lineAddr(1'b0, reqIdx)])
        victim = 1'b0;
      else if (!valid_q[lineAddr(1'b1, reqIdx)])
        victim = 1'b1;
      else
        victim = lru_q[reqIdx];
    end
  end

  assign fillWord = (30'(fillTag_q) << (OFF_W + IDX_W))
                  | (30'(fillIdx_q) << OFF_W)
                  | 30'(32'(cnt_q) & 32'(BLOCK_WORDS - 1));

  assign ihit       = (state_q == LOOKUP) && imemREN && !flush && lookupHit;
  assign imemload   = ihit ? data_q[wordSlot(lineAddr(hitWay, reqIdx), reqOff)] : 32'd0;
  assign iREN       = (state_q == FILL);
  assign iaddr      = (state_q == FILL) ? {fillWord, 2'b00} : imemaddr;
  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;

  // Control FSM: lookup/fill sequencing, valid and LRU bookkeeping, counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= LOOKUP;
      valid_q     <= '0;
      lru_q       <= '0;
      fillTag_q   <= '0;
      fillIdx_q   <= '0;
      cnt_q       <= '0;
      victim_q    <= 1'b0;
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
        lru_q   <= '0;
      end
      case (state_q)
        LOOKUP: begin
          if (!flush && imemREN) begin
            if (lookupHit) begin
              if (WAYS == 2) lru_q[reqIdx] <= ~hitWay;
              if (hitCount_q != 32'hFFFF_FFFF) hitCount_q <= hitCount_q + 32'd1;
            end else begin
              fillTag_q <= reqTag;
              fillIdx_q <= reqIdx;
              victim_q  <= victim;
              cnt_q     <= '0;
              valid_q[lineAddr(victim, reqIdx)] <= 1'b0;
              if (missCount_q != 32'hFFFF_FFFF) missCount_q <= missCount_q + 32'd1;
              state_q   <= FILL;
            end
          end
        end
        FILL: begin
          if (flush) begin
            state_q <= LOOKUP;
          end else if (!iwait) begin
            if (lastWord) begin
              valid_q[lineAddr(victim_q, fillIdx_q)] <= 1'b1;
              if (WAYS == 2) lru_q[fillIdx_q] <= ~victim_q;
              state_q <= LOOKUP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= LOOKUP;
      endcase
    end
  end

  // Line storage: each accepted fill word lands in the victim line; tag goes in with the last word.
  always_ff @(posedge CLK) begin
    if (fillAccept) begin
      data_q[wordSlot(lineAddr(victim_q, fillIdx_q), cnt_q)] <= iload;
      if (lastWord) tag_q[lineAddr(victim_q, fillIdx_q)] <= fillTag_q;
    end
  end

endmodule
